// File: rtl/mem_pkg.sv
// Shared constants and state type for the MEM-stage load/store sequencer.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

endpackage

// File: rtl/lsu_lane_format.sv
// Byte-lane formatting for RV32I loads/stores: byte enables, store replication,
// load lane extraction with sign/zero extension, and alignment/legality check.
module lsu_lane_format
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] fmt_wdata,
    output logic [31:0] fmt_rdata,
    output logic        misaligned
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign byte_shift = mem_rdata >> {addr_lo, 3'b000};
    assign half_shift = mem_rdata >> {addr_lo[1], 4'b0000};
    assign lane_b     = byte_shift[7:0];
    assign lane_h     = half_shift[15:0];

    always_comb begin
        be         = '0;
        fmt_wdata  = '0;
        fmt_rdata  = '0;
        misaligned = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be        = 4'b0001 << addr_lo;
                    fmt_wdata = {4{wdata[7:0]}};
                end
                F3_H: begin
                    misaligned = addr_lo[0];
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata  = {2{wdata[15:0]}};
                end
                F3_W: begin
                    misaligned = |addr_lo;
                    be         = '1;
                    fmt_wdata  = wdata;
                end
                default: misaligned = 1'b1;
            endcase
        end else begin
            be = '1;
            case (funct3)
                F3_B:  fmt_rdata = {{24{lane_b[7]}}, lane_b};
                F3_BU: fmt_rdata = {24'b0, lane_b};
                F3_H: begin
                    misaligned = addr_lo[0];
                    fmt_rdata  = {{16{lane_h[15]}}, lane_h};
                end
                F3_HU: begin
                    misaligned = addr_lo[0];
                    fmt_rdata  = {16'b0, lane_h};
                end
                F3_W: begin
                    misaligned = |addr_lo;
                    fmt_rdata  = mem_rdata;
                end
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one RV32I load/store onto a req/ready data memory with variable
// latency, stalling the pipeline until completion or timeout.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata_out,
    output logic            fault,
    output logic            misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_off;
    logic [2:0]       lat_f3;

    logic             is_store_in;
    logic             is_mem;
    logic             accept;
    logic             timed_out;
    logic [1:0]       f_off;
    logic [2:0]       f_f3;
    logic             f_store;
    logic [3:0]       fmt_be;
    logic [XLEN-1:0]  fmt_wdata;
    logic [XLEN-1:0]  fmt_rdata;
    logic             fmt_mis;

    assign is_store_in = (opcode == OP_STORE);
    assign is_mem      = (opcode == OP_LOAD) || is_store_in;

    // The formatter sees the live request in IDLE and the latched one while the
    // access is outstanding, so one instance serves both store and load paths.
    assign f_off   = (state == IDLE) ? addr[1:0]   : lat_off;
    assign f_f3    = (state == IDLE) ? funct3      : lat_f3;
    assign f_store = (state == IDLE) ? is_store_in : mem_we;

    lsu_lane_format u_fmt (
        .addr_lo    (f_off),
        .funct3     (f_f3),
        .is_store   (f_store),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .be         (fmt_be),
        .fmt_wdata  (fmt_wdata),
        .fmt_rdata  (fmt_rdata),
        .misaligned (fmt_mis)
    );

    assign accept     = (state == IDLE) && start && is_mem && !fmt_mis;
    assign misaligned = (state == IDLE) && start && is_mem && fmt_mis;
    assign stall      = accept || (state == ACCESS);
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_off   <= '0;
            lat_f3    <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata_out <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store_in;
                        mem_addr  <= {addr[XLEN-1:2], 2'b00};
                        mem_be    <= fmt_be;
                        mem_wdata <= is_store_in ? fmt_wdata : '0;
                        lat_off   <= addr[1:0];
                        lat_f3    <= funct3;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        rdata_out <= mem_we ? '0 : fmt_rdata;
                        mem_req   <= 1'b0;
                        fault     <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (timed_out) begin
                        rdata_out <= '0;
                        mem_req   <= 1'b0;
                        fault     <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: store/load formatting,
// misalignment rejection, timeout abort and mid-access reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_out;
    logic        fault;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [31:0] RD_WORD = 32'h80FF7F01;
    localparam logic [31:0] WR_WORD = 32'h5C3D5467;

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata_out  (rdata_out),
        .fault      (fault),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full accepted access; mem_ready is raised on ACCESS cycle 'lat'.
    task automatic run_access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int unsigned lat, input logic [3:0] ebe, input logic ewe,
                              input logic [31:0] ewd, input logic [31:0] erd);
        start = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'b0; mem_rdata = rd;
        #1;
        check({tag, " idle stall"}, {31'b0, stall}, 32'd1);
        check({tag, " idle mis"}, {31'b0, misaligned}, 32'd0);
        step();
        check({tag, " we"}, {31'b0, mem_we}, {31'b0, ewe});
        check({tag, " addr"}, mem_addr, ewd === ewd ? {a[31:2], 2'b00} : 32'd0);
        check({tag, " be"}, {28'b0, mem_be}, {28'b0, ebe});
        check({tag, " wdata"}, mem_wdata, ewd);
        for (int unsigned c = 1; c <= lat; c++) begin
            check({tag, " acc req"}, {31'b0, mem_req}, 32'd1);
            check({tag, " acc stall"}, {31'b0, stall}, 32'd1);
            check({tag, " acc done"}, {31'b0, done}, 32'd0);
            if (c == lat) mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
        end
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " fault"}, {31'b0, fault}, 32'd0);
        check({tag, " rdata"}, rdata_out, erd);
        check({tag, " done stall"}, {31'b0, stall}, 32'd0);
        check({tag, " done req"}, {31'b0, mem_req}, 32'd0);
        start = 1'b0;
        step();
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
        check({tag, " post req"}, {31'b0, mem_req}, 32'd0);
    endtask

    task automatic run_misaligned(input string tag, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] a);
        start = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = WR_WORD;
        #1;
        check({tag, " mis"}, {31'b0, misaligned}, 32'd1);
        check({tag, " stall"}, {31'b0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, " req"}, {31'b0, mem_req}, 32'd0);
            check({tag, " done"}, {31'b0, done}, 32'd0);
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        check("rst req", {31'b0, mem_req}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst fault", {31'b0, fault}, 32'd0);
        check("rst rdata", rdata_out, 32'd0);
        check("rst be", {28'b0, mem_be}, 32'd0);
        check("rst addr", mem_addr, 32'd0);
        check("rst stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;
        step();

        run_access("sb",  ST, 3'b000, 32'h102, WR_WORD, RD_WORD, 2, 4'b0100, 1'b1, 32'h67676767, 32'h0);
        run_access("sh",  ST, 3'b001, 32'h102, WR_WORD, RD_WORD, 1, 4'b1100, 1'b1, 32'h54675467, 32'h0);
        run_access("sw",  ST, 3'b010, 32'h104, WR_WORD, RD_WORD, 3, 4'b1111, 1'b1, 32'h5C3D5467, 32'h0);
        run_access("lb3", LD, 3'b000, 32'h3,   WR_WORD, RD_WORD, 1, 4'b1111, 1'b0, 32'h0, 32'hFFFFFF80);
        run_access("lbu3",LD, 3'b100, 32'h3,   WR_WORD, RD_WORD, 2, 4'b1111, 1'b0, 32'h0, 32'h00000080);
        run_access("lb1", LD, 3'b000, 32'h1,   WR_WORD, RD_WORD, 1, 4'b1111, 1'b0, 32'h0, 32'h0000007F);
        run_access("lh2", LD, 3'b001, 32'h2,   WR_WORD, RD_WORD, 4, 4'b1111, 1'b0, 32'h0, 32'hFFFF80FF);
        run_access("lhu2",LD, 3'b101, 32'h2,   WR_WORD, RD_WORD, 1, 4'b1111, 1'b0, 32'h0, 32'h000080FF);
        run_access("lw0", LD, 3'b010, 32'h0,   WR_WORD, RD_WORD, 1, 4'b1111, 1'b0, 32'h0, 32'h80FF7F01);

        run_misaligned("lw102", LD, 3'b010, 32'h102);
        run_misaligned("sh101", ST, 3'b001, 32'h101);
        run_misaligned("st f3", ST, 3'b100, 32'h100);

        start = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; addr = 32'h102;
        #1;
        check("nonmem stall", {31'b0, stall}, 32'd0);
        check("nonmem mis", {31'b0, misaligned}, 32'd0);
        step();
        check("nonmem req", {31'b0, mem_req}, 32'd0);
        start = 1'b0;
        step();

        // mem_ready on the final counted cycle still completes normally.
        run_access("lw race", LD, 3'b010, 32'h8, WR_WORD, RD_WORD, 16, 4'b1111, 1'b0, 32'h0, 32'h80FF7F01);

        start = 1'b1; opcode = LD; funct3 = 3'b010; addr = 32'h200; mem_ready = 1'b0;
        #1;
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req !== 1'b1) break;
            n++;
            step();
        end
        check("tmo cycles", n, 32'd16);
        check("tmo done", {31'b0, done}, 32'd1);
        check("tmo fault", {31'b0, fault}, 32'd1);
        check("tmo rdata", rdata_out, 32'd0);
        start = 1'b0;
        step();
        check("tmo pulse", {31'b0, done}, 32'd0);
        check("tmo fault clr", {31'b0, fault}, 32'd0);

        start = 1'b1; opcode = ST; funct3 = 3'b010; addr = 32'h300; wdata = WR_WORD;
        #1;
        step();
        step();
        step();
        check("rst mid req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1; start = 1'b0;
        step();
        check("rst mid req drop", {31'b0, mem_req}, 32'd0);
        check("rst mid stall", {31'b0, stall}, 32'd0);
        check("rst mid done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        step();
        check("rst mid no done", {31'b0, done}, 32'd0);
        check("rst mid idle req", {31'b0, mem_req}, 32'd0);

        run_access("post rst sb", ST, 3'b000, 32'h101, WR_WORD, RD_WORD, 1, 4'b0010, 1'b1, 32'h67676767, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one RV32I load or store from the MEM stage onto a single-port data memory that uses a req/ready handshake and has variable latency.
- Store path: generates byte enables, lane-aligns and replicates write data.
- Load path: extracts the addressed lane and sign- or zero-extends it.
- Stalls the pipeline until the memory responds or a timeout expires.
- Sits between the MEM-stage store-data formatter / load writeback and the data memory.

Parameters:
- XLEN, 32, data and address width (RTL supports only 32).
- TIMEOUT, 16, cycles in ACCESS without mem_ready before the access is aborted with fault.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  MEM stage holds a valid instruction; held until done
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- addr  in  32  effective byte address
- wdata  in  32  rs2 value, unformatted
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse; access finished
- rdata_out  out  32  extended load result, valid while done=1
- fault  out  1  qualifies done; timeout occurred
- misaligned  out  1  combinational exception flag, IDLE only
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-formatted store data
- mem_ready  in  1  memory accepts/completes the request this cycle; load data valid in the same cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Reset (synchronous, active-high): state=IDLE; counter=0; all registered outputs 0 (done, fault, rdata_out, mem_req, mem_we, mem_addr, mem_be, mem_wdata).
  - Reset asserted mid-ACCESS drops mem_req at that edge; no done is produced.
- is_mem = (opcode==0000011) or (opcode==0100011).
- Legal funct3:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  - stores: 000 sb, 001 sh, 010 sw
  - any other funct3 is treated as misaligned.
- Misaligned conditions: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - If start, is_mem and misaligned → misaligned=1 combinationally, stall=0, no request, state stays IDLE.
  - If start, is_mem and aligned → latch the request fields, assert mem_req/we/addr/be/wdata registered, go to ACCESS. stall=1 combinationally in this cycle.
  - If not is_mem → no action.
- ACCESS:
  - stall=1; mem_req held high with all mem_* fields stable.
  - counter increments every cycle.
  - On mem_ready → capture formatted load data (0 for stores) into rdata_out, drop mem_req, fault=0, go to DONE.
  - If counter==TIMEOUT-1 without mem_ready → drop mem_req, fault=1, rdata_out=0, go to DONE.
  - mem_ready in the same cycle as the timeout wins (normal completion).
- DONE: done=1, stall=0 for exactly one cycle; start is ignored; return to IDLE and clear counter.
- Minimum latency: start at cycle 0, mem_ready at cycle 1 → done at cycle 2. A back-to-back access starts at cycle 3.
- Store formatting (o = addr[1:0]):
  - sb: be = 0001<<o; wdata = byte[7:0] replicated ×4.
  - sh: be = 0011<<(2·addr[1]); wdata = half[15:0] replicated ×2.
  - sw: be = 1111; wdata unchanged.
- Load formatting:
  - byte = mem_rdata[8o+7:8o]; half = mem_rdata[16·addr[1]+15:16·addr[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - Loads drive mem_be=1111, mem_we=0.

Decomposition:
- Shared package mem_pkg:
  - opcode constants OP_LOAD, OP_STORE
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum IDLE/ACCESS/DONE
- One sub-module: lsu_lane_format, purely combinational. Inputs addr[1:0], funct3, wdata, mem_rdata; outputs be, fmt_wdata, fmt_rdata, misaligned.
- The FSM and timeout counter stay in mem_access_ctrl.

Test Plan:
- sb, addr=0x102, wdata=0x5C3D5467, mem_ready on 2nd ACCESS cycle → mem_be=0100, mem_wdata=0x67676767, mem_addr=0x100, mem_we=1; stall high 3 cycles; done pulses once.
- sh, addr=0x102, same wdata → be=1100, mem_wdata=0x54675467. sw, addr=0x104 → be=1111, mem_wdata=0x5C3D5467.
- Loads with mem_rdata=0x80FF7F01:
  - lb @0x3 → rdata_out=0xFFFFFF80
  - lbu @0x3 → 0x00000080
  - lb @0x1 → 0x0000007F
  - lh @0x2 → 0xFFFF80FF
  - lhu @0x2 → 0x000080FF
  - lw @0x0 → 0x80FF7F01
- lw addr=0x102 and sh addr=0x101 → misaligned=1, stall=0, mem_req never asserted, state stays IDLE.
- mem_ready held low, TIMEOUT=16 → mem_req drops after 16 ACCESS cycles; done=1 with fault=1, rdata_out=0.
- Reset asserted on the 3rd ACCESS cycle → mem_req=0 and stall=0 after that edge; no done pulse. A following start behaves normally.
